// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: per-register readiness countdown, load-use and
// branch-operand stall detection, and a saturating stall-cycle statistic.

module id_sb_cell #(
  parameter int CW       = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          is_load,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] LD_VAL  = CW'(LOAD_LAT + 1);
  localparam logic [CW-1:0] ALU_VAL = CW'(1);

  // A fresh write overrides the countdown of the previous producer.
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (set)          cnt <= is_load ? LD_VAL : ALU_VAL;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end
endmodule

module id_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_wr_en,
  input  logic [REG_W-1:0]  id_wr_reg,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              pc_if_id_write,
  output logic              bubble,
  output logic [STAT_W-1:0] stall_count
);
  localparam int NREG = 2 ** REG_W;
  localparam int CW   = $clog2(LOAD_LAT + 2);

  logic [NREG-1:0][CW-1:0] cnt;
  logic [CW-1:0]           c_rs, c_rt;
  logic                    haz_rs, haz_rt, stall, issue;

  assign c_rs = cnt[id_rs];
  assign c_rt = cnt[id_rt];

  // Branches resolve in ID so they need the value fully written back (cnt==0);
  // EX consumers can take it off the forwarding path one cycle earlier.
  assign haz_rs = id_uses_rs && (id_rs != '0) &&
                  (id_is_branch ? (c_rs != '0) : (c_rs > CW'(1)));
  assign haz_rt = id_uses_rt && (id_rt != '0) &&
                  (id_is_branch ? (c_rt != '0) : (c_rt > CW'(1)));

  assign stall          = id_valid && !flush && (haz_rs || haz_rt);
  assign issue          = id_valid && !flush && !stall;
  assign pc_if_id_write = !stall;
  assign bubble         = stall || flush || !id_valid;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_cell
      id_sb_cell #(.CW(CW), .LOAD_LAT(LOAD_LAT)) u_cell (
        .clk     (clk),
        .reset   (reset),
        .set     (issue && id_wr_en && (id_wr_reg == REG_W'(r))),
        .is_load (id_is_load),
        .cnt     (cnt[r])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              stall_count <= '0;
    else if (stall && (stall_count != '1))  stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: three configurations driven independently, checked
// every cycle against a ready-time model plus hand-computed stall counts.

module tb_id_scoreboard;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt;
    logic       urs, urt, br, wr;
    logic [4:0] wreg;
    logic       ld, fl;
  } in_t;

  localparam in_t IDLE = '0;

  logic        clk = 0, reset = 0;
  in_t         din [3];
  logic [2:0]  pcw, bub;
  logic [15:0] sc  [3];
  logic [1:0]  sc2w;

  int total = 0, bad = 0;
  bit started = 0;
  int lat   [3] = '{1, 3, 1};
  int smax  [3] = '{65535, 65535, 3};
  int rdy_ex[3][32], rdy_br[3][32], mstat[3];
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    id_scoreboard #(.REG_W(5), .LOAD_LAT(k == 0 ? 1 : 3), .STAT_W(16)) u_dut (
      .clk(clk), .reset(reset), .id_valid(din[k].valid), .id_rs(din[k].rs), .id_rt(din[k].rt),
      .id_uses_rs(din[k].urs), .id_uses_rt(din[k].urt), .id_is_branch(din[k].br),
      .id_wr_en(din[k].wr), .id_wr_reg(din[k].wreg), .id_is_load(din[k].ld), .flush(din[k].fl),
      .pc_if_id_write(pcw[k]), .bubble(bub[k]), .stall_count(sc[k]));
  end

  id_scoreboard #(.REG_W(5), .LOAD_LAT(1), .STAT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(din[2].valid), .id_rs(din[2].rs), .id_rt(din[2].rt),
    .id_uses_rs(din[2].urs), .id_uses_rt(din[2].urt), .id_is_branch(din[2].br),
    .id_wr_en(din[2].wr), .id_wr_reg(din[2].wreg), .id_is_load(din[2].ld), .flush(din[2].fl),
    .pc_if_id_write(pcw[2]), .bubble(bub[2]), .stall_count(sc2w));
  assign sc[2] = {14'b0, sc2w};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a result becomes usable by EX at an absolute cycle, by ID one cycle later.
  function automatic bit m_haz(int k, logic [4:0] r, logic u, logic br);
    if (!u || r == 0) return 0;
    return cyc < (br ? rdy_br[k][r] : rdy_ex[k][r]);
  endfunction

  function automatic bit m_stall(int k);
    return din[k].valid && !din[k].fl &&
           (m_haz(k, din[k].rs, din[k].urs, din[k].br) || m_haz(k, din[k].rt, din[k].urt, din[k].br));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mstat[k] = 0;
        for (int r = 0; r < 32; r++) begin rdy_ex[k][r] = 0; rdy_br[k][r] = 0; end
      end else begin
        bit st;
        st = m_stall(k);
        if (st && mstat[k] < smax[k]) mstat[k]++;
        if (din[k].valid && !din[k].fl && !st && din[k].wr && din[k].wreg != 0) begin
          rdy_ex[k][din[k].wreg] = cyc + 1 + (din[k].ld ? lat[k] : 0);
          rdy_br[k][din[k].wreg] = rdy_ex[k][din[k].wreg] + 1;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit st;
        st = m_stall(k);
        chk($sformatf("pcw[%0d]", k), int'(pcw[k]), int'(!st));
        chk($sformatf("bubble[%0d]", k), int'(bub[k]), int'(st || din[k].fl || !din[k].valid));
        chk($sformatf("stall_count[%0d]", k), int'(sc[k]), mstat[k]);
      end
    end
  end

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic br,
                             logic wr, logic [4:0] wreg, logic ld);
    in_t t;
    t = '0;
    t.valid = 1; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.br = br;
    t.wr = wr; t.wreg = wreg; t.ld = ld;
    return t;
  endfunction

  // Present one instruction to instance k and count its stall cycles.
  task automatic run(input int k, input in_t ins, output int stalls);
    stalls = 0;
    din[k] = ins;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pcw[k]) break;
      stalls++;
    end
    if (stalls >= 20) chk($sformatf("stall_timeout[%0d]", k), stalls, 0);
    @(posedge clk); #2;
    din[k] = IDLE;
  endtask

  in_t lw8, fl_ins;
  int  n, s0;

  initial begin
    for (int k = 0; k < 3; k++) din[k] = IDLE;
    reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    started = 1;
    @(negedge clk);
    chk("reset_pcw", int'(pcw), 7);
    chk("reset_bubble", int'(bub), 7);
    chk("reset_sc0", int'(sc[0]), 0);
    @(posedge clk); #2;

    // LOAD_LAT=1 load-use
    lw8 = mk(0, 0, 0, 0, 0, 1, 8, 1);
    run(0, lw8, n);                          chk("lw8_stalls", n, 0);
    run(0, mk(8, 1, 1, 1, 0, 1, 3, 0), n);   chk("lat1_add_stalls", n, 1);
    chk("lat1_sc", int'(sc[0]), 1);

    // ALU producer vs branch / EX consumer
    run(0, mk(1, 2, 1, 1, 0, 1, 9, 0), n);   chk("add9", n, 0);
    run(0, mk(9, 0, 1, 1, 1, 0, 0, 0), n);   chk("beq9_stalls", n, 1);
    run(0, mk(1, 2, 1, 1, 0, 1, 9, 0), n);   chk("add9b", n, 0);
    run(0, mk(9, 2, 1, 1, 0, 1, 10, 0), n);  chk("add10_9_stalls", n, 0);

    // register 0 never hazards
    run(0, mk(0, 0, 0, 0, 0, 1, 0, 1), n);   chk("lw0", n, 0);
    run(0, mk(0, 0, 1, 1, 0, 1, 4, 0), n);   chk("add_r0_stalls", n, 0);

    // read and write the same register, then rs==rt
    run(0, mk(0, 0, 0, 0, 0, 1, 5, 1), n);
    run(0, mk(5, 5, 1, 1, 0, 1, 5, 0), n);   chk("add5_5_stalls", n, 1);
    run(0, mk(5, 0, 1, 0, 1, 0, 0, 0), n);   chk("beq5_stalls", n, 1);
    s0 = sc[0];
    run(0, mk(0, 0, 0, 0, 0, 1, 6, 1), n);
    run(0, mk(6, 6, 1, 1, 0, 1, 7, 0), n);   chk("rs_eq_rt_stalls", n, 1);
    chk("rs_eq_rt_sc", int'(sc[0]) - s0, 1);

    // flushed stalled branch: advances, bubbles, writes nothing, no count
    run(0, mk(0, 0, 0, 0, 0, 1, 7, 1), n);
    s0 = sc[0];
    fl_ins = mk(7, 0, 1, 0, 1, 1, 11, 1);
    fl_ins.fl = 1;
    din[0] = fl_ins;
    @(negedge clk);
    chk("flush_pcw", int'(pcw[0]), 1);
    chk("flush_bubble", int'(bub[0]), 1);
    @(posedge clk); #2 din[0] = IDLE;
    chk("flush_sc", int'(sc[0]), s0);
    run(0, mk(11, 0, 1, 0, 0, 0, 0, 0), n);  chk("after_flush_r11", n, 0);

    // LOAD_LAT=3
    run(1, lw8, n);
    run(1, mk(8, 0, 1, 0, 1, 0, 0, 0), n);   chk("lat3_beq_stalls", n, 4);
    run(1, lw8, n);
    run(1, mk(8, 0, 1, 0, 0, 1, 3, 0), n);   chk("lat3_add_stalls", n, 3);
    chk("lat3_sc", int'(sc[1]), 7);
    // a flush in between must not clear the older load's counter
    run(1, mk(0, 0, 0, 0, 0, 1, 12, 1), n);
    fl_ins = mk(0, 0, 0, 0, 0, 1, 13, 0);
    fl_ins.fl = 1;
    run(1, fl_ins, n);
    run(1, mk(12, 0, 1, 0, 0, 0, 0, 0), n);  chk("lat3_flush_keep", n, 2);

    // STAT_W=2 saturation: three load/branch pairs -> 6 stalls, capped at 3
    for (int i = 0; i < 3; i++) begin
      run(2, lw8, n);
      run(2, mk(8, 0, 1, 0, 1, 0, 0, 0), n); chk("sat_beq_stalls", n, 2);
    end
    chk("sat_sc", int'(sc[2]), 3);

    // reset mid-stall
    run(2, lw8, n);
    din[2] = mk(8, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("midstall_pcw", int'(pcw[2]), 0);
    reset = 1;
    @(posedge clk); #2 reset = 0;
    @(negedge clk);
    chk("post_reset_pcw", int'(pcw[2]), 1);
    chk("post_reset_sc", int'(sc[2]), 0);
    @(posedge clk); #2 din[2] = IDLE;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
